// File: rtl/div_iter_unit_pkg.sv
// Shared definitions for the iterative divider.
//   DIV_WIDTH   default operand width
//   divState_t  FSM state encodings (IDLE/BUSY/DONE)
package div_iter_unit_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } divState_t;

endpackage

// File: rtl/div_iter_unit_step.sv
// One restoring-division iteration (combinational).
// Ports:
//   remIn, quoIn   partial remainder and quotient/dividend shift register
//   divisor        divisor magnitude
//   remOut, quoOut state after shifting {rem,quo} left by one and trial subtraction
module div_iter_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic [WIDTH-1:0] quoIn,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remOut,
    output logic [WIDTH-1:0] quoOut
);

    logic [WIDTH:0]   remShift;
    logic [WIDTH+1:0] trial;

    always_comb begin
        remShift = {remIn, quoIn[WIDTH-1]};
        // One extra bit beyond the shifted remainder so the sign of the trial is exact
        // even for divisors near 2^WIDTH.
        trial    = {1'b0, remShift} - {2'b00, divisor};
        remOut   = remShift[WIDTH-1:0];
        quoOut   = {quoIn[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH+1]) begin
            remOut    = trial[WIDTH-1:0];
            quoOut[0] = 1'b1;
        end
    end

endmodule

// File: rtl/div_iter_unit.sv
// Multi-cycle radix-2 restoring divider for E-stage DIV/DIVU.
//   state    | meaning
//   DIV_IDLE | waiting for StartDivE; operands sampled here only
//   DIV_BUSY | one restoring step per cycle, WIDTH steps
//   DIV_DONE | DivReadyE high for this single cycle, then back to IDLE
// Ports:
//   clk, rst     clock / asynchronous active-low reset
//   StartDivE    request, held by the E-stage stall until DivReadyE
//   SignedDivE   1 = DIV (two's complement), 0 = DIVU
//   SrcAE, SrcBE dividend, divisor
//   AnnulDivE    cancel the in-flight operation
//   DivReadyE    one-cycle completion pulse
//   DivResultE   {remainder, quotient}, registered
//   DivBusyE     high while in BUSY
module div_iter_unit
    import div_iter_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               StartDivE,
    input  logic               SignedDivE,
    input  logic [WIDTH-1:0]   SrcAE,
    input  logic [WIDTH-1:0]   SrcBE,
    input  logic               AnnulDivE,
    output logic               DivReadyE,
    output logic [2*WIDTH-1:0] DivResultE,
    output logic               DivBusyE
);

    localparam int CW = $clog2(WIDTH);

    divState_t        state, stateNext;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] remReg, quoReg, divisorReg;
    logic             qNeg, rNeg;

    logic             startAcc, signA, signB, divZero, lastStep;
    logic [WIDTH-1:0] magA, magB;
    logic [WIDTH-1:0] remStep, quoStep, remFix, quoFix;

    div_iter_unit_step #(.WIDTH(WIDTH)) uStep (
        .remIn   (remReg),
        .quoIn   (quoReg),
        .divisor (divisorReg),
        .remOut  (remStep),
        .quoOut  (quoStep)
    );

    always_comb begin
        startAcc = StartDivE & ~AnnulDivE;
        signA    = SignedDivE & SrcAE[WIDTH-1];
        signB    = SignedDivE & SrcBE[WIDTH-1];
        // MIN negates to itself, which is the correct unsigned magnitude 2^(WIDTH-1).
        magA     = signA ? (~SrcAE + 1'b1) : SrcAE;
        magB     = signB ? (~SrcBE + 1'b1) : SrcBE;
        divZero  = (SrcBE == '0);
        lastStep = (count == CW'(WIDTH-1));
        quoFix   = qNeg ? (~quoStep + 1'b1) : quoStep;
        remFix   = rNeg ? (~remStep + 1'b1) : remStep;
    end

    always_comb begin
        stateNext = state;
        DivReadyE = 1'b0;
        DivBusyE  = 1'b0;
        case (state)
            DIV_IDLE: begin
                if (startAcc) stateNext = divZero ? DIV_DONE : DIV_BUSY;
            end
            DIV_BUSY: begin
                DivBusyE = 1'b1;
                if (AnnulDivE)     stateNext = DIV_IDLE;
                else if (lastStep) stateNext = DIV_DONE;
            end
            DIV_DONE: begin
                DivReadyE = 1'b1;
                stateNext = DIV_IDLE;
            end
            default: stateNext = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= DIV_IDLE;
        else      state <= stateNext;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count      <= '0;
            remReg     <= '0;
            quoReg     <= '0;
            divisorReg <= '0;
            qNeg       <= 1'b0;
            rNeg       <= 1'b0;
            DivResultE <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (startAcc) begin
                        remReg     <= '0;
                        quoReg     <= magA;
                        divisorReg <= magB;
                        qNeg       <= signA ^ signB;
                        rNeg       <= signA;
                        count      <= '0;
                        if (divZero) DivResultE <= {SrcAE, {WIDTH{1'b1}}};
                    end
                end
                DIV_BUSY: begin
                    // Annul wins over completion: nothing advances, result untouched.
                    if (!AnnulDivE) begin
                        remReg <= remStep;
                        quoReg <= quoStep;
                        count  <= count + 1'b1;
                        if (lastStep) DivResultE <= {remFix, quoFix};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter_unit.sv
module tb_div_iter_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         StartDivE, SignedDivE, AnnulDivE;
    logic [W-1:0] SrcAE, SrcBE;
    logic         DivReadyE, DivBusyE;
    logic [2*W-1:0] DivResultE;

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    div_iter_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .StartDivE  (StartDivE),
        .SignedDivE (SignedDivE),
        .SrcAE      (SrcAE),
        .SrcBE      (SrcBE),
        .AnnulDivE  (AnnulDivE),
        .DivReadyE  (DivReadyE),
        .DivResultE (DivResultE),
        .DivBusyE   (DivBusyE)
    );

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic startOp(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        StartDivE  = 1'b1;
        SignedDivE = sgn;
        SrcAE      = a;
        SrcBE      = b;
    endtask

    // Counts cycles until DivReadyE; operands are scrambled mid-operation to show
    // they are sampled only at start.
    task automatic waitReady(input int scrambleAt, input bit holdStart,
                             output int lat, output int busyCnt);
        lat = 0;
        busyCnt = 0;
        do begin
            cycle();
            lat++;
            if (DivBusyE) busyCnt++;
            if (lat == scrambleAt && !DivReadyE) begin
                SrcAE = $urandom;
                SrcBE = $urandom;
            end
        end while (!DivReadyE && lat < 100);
        if (!holdStart) StartDivE = 1'b0;
    endtask

    task automatic runOp(input string tag, input logic sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [63:0] expRes, input int expLat);
        int lat, busyCnt;
        startOp(sgn, a, b);
        waitReady(2, 1'b0, lat, busyCnt);
        checkVal({tag, "_lat"}, 64'(lat), 64'(expLat));
        checkVal({tag, "_res"}, DivResultE, expRes);
        checkVal({tag, "_busy"}, 64'(busyCnt), 64'(expLat - 1));
        cycle();
        checkVal({tag, "_pulse1"}, 64'(DivReadyE), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, busyCnt;
        logic [63:0] held;

        rst = 1'b0;
        StartDivE = 1'b0; SignedDivE = 1'b0; AnnulDivE = 1'b0;
        SrcAE = '0; SrcBE = '0;
        @(negedge clk);
        @(negedge clk);
        checkVal("rst_ready", 64'(DivReadyE), 64'd0);
        checkVal("rst_busy", 64'(DivBusyE), 64'd0);
        checkVal("rst_res", DivResultE, 64'd0);
        rst = 1'b1;
        cycle();

        runOp("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        runOp("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        runOp("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33);
        runOp("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33);
        runOp("divu_zero", 1'b0, 32'h1234, 32'h0, {32'h0000_1234, 32'hFFFF_FFFF}, 1);
        runOp("div_zero", 1'b1, 32'hFFFF_FF00, 32'h0, {32'hFFFF_FF00, 32'hFFFF_FFFF}, 1);
        runOp("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, 33);
        runOp("divu_m1_m2", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, {32'h1, 32'h1}, 33);
        runOp("div_m1_m2", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, {32'hFFFF_FFFF, 32'h0}, 33);
        runOp("divu_1000_3", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 33);

        // Annul in BUSY at C10: IDLE in C11, no pulse, result unchanged.
        held = DivResultE;
        startOp(1'b0, 32'd5000, 32'd9);
        repeat (10) cycle();
        AnnulDivE = 1'b1;
        cycle();
        AnnulDivE = 1'b0;
        StartDivE = 1'b0;
        checkVal("ann_busy", 64'(DivBusyE), 64'd0);
        checkVal("ann_ready", 64'(DivReadyE), 64'd0);
        checkVal("ann_res", DivResultE, held);
        cycle();
        checkVal("ann_ready2", 64'(DivReadyE), 64'd0);
        runOp("ann_restart", 1'b0, 32'd5000, 32'd9, {32'd5, 32'd555}, 33);

        // Annul in the final BUSY cycle beats completion.
        held = DivResultE;
        startOp(1'b1, 32'hFFFF_FF9C, 32'd7);
        repeat (32) cycle();
        checkVal("annlast_busy_pre", 64'(DivBusyE), 64'd1);
        AnnulDivE = 1'b1;
        StartDivE = 1'b0;
        cycle();
        AnnulDivE = 1'b0;
        checkVal("annlast_ready", 64'(DivReadyE), 64'd0);
        checkVal("annlast_busy", 64'(DivBusyE), 64'd0);
        checkVal("annlast_res", DivResultE, held);

        // Start together with annul in IDLE is ignored.
        startOp(1'b0, 32'd10, 32'd3);
        AnnulDivE = 1'b1;
        cycle();
        checkVal("annidle_busy", 64'(DivBusyE), 64'd0);
        checkVal("annidle_ready", 64'(DivReadyE), 64'd0);
        StartDivE = 1'b0;
        AnnulDivE = 1'b0;
        cycle();

        // Back-to-back: StartDivE stays high through DONE; second op begins in the
        // IDLE cycle after the pulse.
        startOp(1'b0, 32'd100, 32'd7);
        waitReady(2, 1'b1, lat, busyCnt);
        checkVal("b2b_lat1", 64'(lat), 64'd33);
        checkVal("b2b_res1", DivResultE, {32'd2, 32'd14});
        startOp(1'b1, 32'hFFFF_FFF9, 32'd2);
        waitReady(3, 1'b0, lat, busyCnt);
        checkVal("b2b_lat2", 64'(lat), 64'd34);
        checkVal("b2b_res2", DivResultE, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        checkVal("b2b_busy2", 64'(busyCnt), 64'd32);
        cycle();

        // Async reset mid-operation.
        startOp(1'b0, 32'd50, 32'd5);
        repeat (5) cycle();
        rst = 1'b0;
        #1;
        checkVal("arst_busy", 64'(DivBusyE), 64'd0);
        checkVal("arst_ready", 64'(DivReadyE), 64'd0);
        checkVal("arst_res", DivResultE, 64'd0);
        StartDivE = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cycle();
        checkVal("arst_idle", 64'(DivBusyE), 64'd0);
        runOp("post_rst", 1'b0, 32'd5, 32'd10, {32'd5, 32'd0}, 33);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
